dac_serial_rx: RTL and testbench
================================

# dac_serial_rx

Serial-frame receiver for the LSB-first DAC data stream on `dclk`/`dce_n`/`dout`. It deserialises each frame into a parallel word and presents it over a valid/ready handshake. It flags short frames and overruns and keeps saturating error counters. It sits on the far end of the DAC serial link, either as a loopback checker on the FPGA or in front of a device model in simulation.

## Interface
- `DWIDTH`, 8: bits per frame / output word width (2..32).
- `CNTW`, 8: width of each saturating error counter.

Ports:
- `dclk`  in  1  single clock; all sampling on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `dce_n`  in  1  frame strobe, active low, synchronous to `dclk`.
- `din`  in  1  serial data, LSB first.
- `rdy_i`  in  1  downstream ready.
- `word_o`  out  DWIDTH  received word.
- `vld_o`  out  1  `word_o` valid.
- `ferr_o`  out  1  one-cycle pulse on a short frame.
- `ovf_o`  out  1  one-cycle pulse on a dropped word.
- `ferr_cnt_o`  out  CNTW  saturating count of short frames.
- `ovf_cnt_o`  out  CNTW  saturating count of dropped words.
- `busy_o`  out  1  high while in SHIFT.

## Operation
States:
- **IDLE.** `dce_n` sampled low goes to SHIFT and sets bit index `idx` to 0. `din` is ignored.
- **SHIFT.** Each rising edge with `dce_n` high shifts `din` in at bit position `idx` (LSB first) and increments `idx`.
  - When `idx` reaches DWIDTH-1 and that bit is captured, the word is complete and the state goes to IDLE.
  - If `dce_n` is sampled low while `idx` is below DWIDTH, the frame is short: pulse `ferr_o`, increment `ferr_cnt_o`, discard the partial word, reset `idx` to 0 and stay in SHIFT, because this strobe starts a new frame.
- **Strobe on the word-completion edge.** `dce_n` low on the edge immediately after the last bit, which is back-to-back framing, is legal. That edge lands in IDLE and starts the next frame with no error.
- **Output register.**
  - On word completion with `vld_o` low, or with `vld_o` high and `rdy_i` high on the same edge: `word_o` takes the new word and `vld_o` goes to 1.
  - On word completion with `vld_o` high and `rdy_i` low: the new word is dropped, `word_o` is unchanged, `ovf_o` pulses and `ovf_cnt_o` increments.
  - Otherwise `vld_o` clears when `vld_o` and `rdy_i` are both high.
  - `word_o` is stable while `vld_o` is high.
- **Counters.** Unsigned, saturating at 2^CNTW-1 with no wrap. They are cleared only by reset.
- **`din` during IDLE or on the strobe edge.** Don't-care and never captured; the transmitter may drive X there.

## Timing
- Reset values: state IDLE, `idx` 0, `word_o` 0, `vld_o` 0, `ferr_o` 0, `ovf_o` 0, both counters 0, `busy_o` 0. Reset asserted mid-frame discards the partial word immediately. After reset release the receiver waits in IDLE for a fresh `dce_n` low.
- Edge numbering: let the strobe edge be edge S. Bit k is sampled on edge S+1+k. `vld_o` is high in the cycle after edge S+DWIDTH.
- Latency from the last bit sampled to `vld_o` high is 1 cycle. Minimum frame period is DWIDTH+1 cycles.
- `ferr_o` and `ovf_o` are registered. Each is high for exactly the one cycle after the offending edge.
- `busy_o` is registered and equals (state == SHIFT).
- Simultaneous events:
  - A short-frame strobe and an output handshake on the same edge are independent; both take effect.
  - A counter at saturation does not change, but its pulse output still fires.

## Test plan
1. DWIDTH=8, `rdy_i`=1; strobe then `din` LSB-first bits of 0xA5 -> `word_o`=0xA5 and `vld_o`=1 in the cycle after edge S+8; `ferr_o`=0.
2. Back-to-back frames 0x01, 0x80, 0xFF with strobes every 9 cycles, `rdy_i`=1 -> three `vld_o` pulses carrying 0x01, 0x80, 0xFF; no errors.
3. Strobe, 5 bits, then strobe, then 8 bits of 0x3C -> `ferr_o` pulses once, `ferr_cnt_o`=1, the single delivered word is 0x3C.
4. `rdy_i`=0; frames 0x11 then 0x22 -> `word_o` holds 0x11, `ovf_o` pulses, `ovf_cnt_o`=1. With `rdy_i` raised, `vld_o` drops after 1 cycle and no 0x22 appears.
5. Reset asserted at bit 4 of frame 0x5A, then a clean frame 0x0F -> all outputs at reset values during reset; only 0x0F is delivered and both counters are 0.
6. CNTW=2; 5 short frames -> `ferr_cnt_o` sticks at 3; `ferr_o` pulses 5 times.

Source files
------------

// File: rtl/dac_serial_rx_if.sv
// Parallel word handshake between the serial receiver and its consumer.
// The receiver drives the word and its valid flag, and the consumer answers with ready.
interface dac_serial_rx_if #(
  parameter int DWIDTH = 8
);
  logic [DWIDTH-1:0] word_o;
  logic              vld_o;
  logic              rdy_i;

  modport master (output word_o, output vld_o, input rdy_i);
  modport slave  (input word_o, input vld_o, output rdy_i);
endinterface

// File: rtl/dac_serial_rx.sv
// LSB-first serial frame receiver for the DAC link, with a valid/ready output register
// and saturating counters for short frames and dropped words.
module dac_serial_rx #(
  parameter int DWIDTH = 8,
  parameter int CNTW   = 8
) (
  input  logic                  dclk,
  input  logic                  rst_n,
  input  logic                  dce_n,
  input  logic                  din,
  dac_serial_rx_if.master       stream,
  output logic                  ferr_o,
  output logic                  ovf_o,
  output logic [CNTW-1:0]       ferr_cnt_o,
  output logic [CNTW-1:0]       ovf_cnt_o,
  output logic                  busy_o
);

  localparam int IDXW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DWIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [IDXW-1:0]   r_idx;
  logic [DWIDTH-1:0] r_shift;
  logic [DWIDTH-1:0] r_word;
  logic              r_vld;
  logic              r_ferr;
  logic              r_ovf;
  logic [CNTW-1:0]   r_ferrCnt;
  logic [CNTW-1:0]   r_ovfCnt;
  logic              r_busy;

  logic              w_shiftEn;
  logic              w_complete;
  logic              w_shortFrame;
  logic              w_accept;
  logic              w_drop;
  logic              w_release;
  logic [DWIDTH-1:0] w_newWord;

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A strobe inside SHIFT restarts the frame, so it keeps the state in SHIFT.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (!dce_n) w_nextState = SHIFT;
      SHIFT:   if (dce_n && (r_idx == LAST_IDX)) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_shiftEn    = 1'b0;
    w_complete   = 1'b0;
    w_shortFrame = 1'b0;
    if (r_state == SHIFT) begin
      w_shiftEn    = dce_n;
      w_complete   = dce_n && (r_idx == LAST_IDX);
      w_shortFrame = !dce_n;
    end
    w_accept  = w_complete && (!r_vld || stream.rdy_i);
    w_drop    = w_complete && r_vld && !stream.rdy_i;
    w_release = r_vld && stream.rdy_i;
    w_newWord = {din, r_shift[DWIDTH-2:0]};
  end

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      if (!dce_n || w_complete) begin
        r_idx <= '0;
      end else if (w_shiftEn) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_shiftEn) begin
        r_shift[r_idx] <= din;
      end
    end
  end

  // A completed word is dropped rather than overwriting one the consumer has not taken.
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      r_word    <= '0;
      r_vld     <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovf     <= 1'b0;
      r_ferrCnt <= '0;
      r_ovfCnt  <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_ferr <= w_shortFrame;
      r_ovf  <= w_drop;
      r_busy <= (w_nextState == SHIFT);
      if (w_accept) begin
        r_word <= w_newWord;
        r_vld  <= 1'b1;
      end else if (w_release) begin
        r_vld <= 1'b0;
      end
      if (w_shortFrame && (r_ferrCnt != '1)) begin
        r_ferrCnt <= r_ferrCnt + 1'b1;
      end
      if (w_drop && (r_ovfCnt != '1)) begin
        r_ovfCnt <= r_ovfCnt + 1'b1;
      end
    end
  end

  assign stream.word_o = r_word;
  assign stream.vld_o  = r_vld;
  assign ferr_o        = r_ferr;
  assign ovf_o         = r_ovf;
  assign ferr_cnt_o    = r_ferrCnt;
  assign ovf_cnt_o     = r_ovfCnt;
  assign busy_o        = r_busy;

endmodule

// File: tb/tb_dac_serial_rx.sv
// Randomised bench for dac_serial_rx: two instances (8-bit and 2-bit counters) share one
// stimulus stream and are compared every cycle against a frame-level reference model.
module tb_dac_serial_rx;

  localparam int DW = 8;

  logic dclk  = 1'b0;
  logic rst_n = 1'b0;
  logic dce_n = 1'b1;
  logic din   = 1'b0;
  logic rdy   = 1'b1;

  always #5 dclk = ~dclk;

  dac_serial_rx_if #(.DWIDTH(DW)) ifA ();
  dac_serial_rx_if #(.DWIDTH(DW)) ifB ();
  assign ifA.rdy_i = rdy;
  assign ifB.rdy_i = rdy;

  logic       ferrA, ovfA, busyA;
  logic [7:0] ferrCntA, ovfCntA;
  logic       ferrB, ovfB, busyB;
  logic [1:0] ferrCntB, ovfCntB;

  dac_serial_rx #(.DWIDTH(DW), .CNTW(8)) dutA (
    .dclk(dclk), .rst_n(rst_n), .dce_n(dce_n), .din(din), .stream(ifA),
    .ferr_o(ferrA), .ovf_o(ovfA), .ferr_cnt_o(ferrCntA), .ovf_cnt_o(ovfCntA), .busy_o(busyA)
  );

  dac_serial_rx #(.DWIDTH(DW), .CNTW(2)) dutB (
    .dclk(dclk), .rst_n(rst_n), .dce_n(dce_n), .din(din), .stream(ifB),
    .ferr_o(ferrB), .ovf_o(ovfB), .ferr_cnt_o(ferrCntB), .ovf_cnt_o(ovfCntB), .busy_o(busyB)
  );

  int compareCount  = 0;
  int mismatchCount = 0;
  int rdyMode       = 1;
  int ferrSeen      = 0;

  // Reference model: frame progress as a bit count and an accumulated integer word
  bit mInFrame;
  int mBits, mAcc, mWord;
  bit mVld, mFerr, mOvf;
  int mFerr8, mOvf8, mFerr2, mOvf2;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, actual, expected);
    end
  endtask

  function automatic int satInc(input int value, input int maxValue);
    return (value >= maxValue) ? maxValue : value + 1;
  endfunction

  task automatic modelReset();
    mInFrame = 0; mBits = 0; mAcc = 0; mWord = 0;
    mVld = 0; mFerr = 0; mOvf = 0;
    mFerr8 = 0; mOvf8 = 0; mFerr2 = 0; mOvf2 = 0;
  endtask

  task automatic modelEdge();
    bit complete;
    complete = 0;
    mFerr = 0;
    mOvf  = 0;
    if (!mInFrame) begin
      if (!dce_n) begin
        mInFrame = 1; mBits = 0; mAcc = 0;
      end
    end else if (!dce_n) begin
      mFerr = 1; mBits = 0; mAcc = 0;
    end else begin
      mAcc = mAcc + (int'(din) << mBits);
      mBits++;
      if (mBits == DW) begin
        complete = 1;
        mInFrame = 0;
      end
    end
    if (complete) begin
      if (!mVld || rdy) begin
        mWord = mAcc;
        mVld  = 1;
      end else begin
        mOvf = 1;
      end
    end else if (mVld && rdy) begin
      mVld = 0;
    end
    if (mFerr) begin
      mFerr8 = satInc(mFerr8, 255);
      mFerr2 = satInc(mFerr2, 3);
    end
    if (mOvf) begin
      mOvf8 = satInc(mOvf8, 255);
      mOvf2 = satInc(mOvf2, 3);
    end
  endtask

  task automatic checkAll();
    checkOutput("wordA", int'(ifA.word_o), mWord);
    checkOutput("vldA", int'(ifA.vld_o), int'(mVld));
    checkOutput("ferrA", int'(ferrA), int'(mFerr));
    checkOutput("ovfA", int'(ovfA), int'(mOvf));
    checkOutput("busyA", int'(busyA), int'(mInFrame));
    checkOutput("ferrCntA", int'(ferrCntA), mFerr8);
    checkOutput("ovfCntA", int'(ovfCntA), mOvf8);
    checkOutput("wordB", int'(ifB.word_o), mWord);
    checkOutput("vldB", int'(ifB.vld_o), int'(mVld));
    checkOutput("ferrB", int'(ferrB), int'(mFerr));
    checkOutput("ovfB", int'(ovfB), int'(mOvf));
    checkOutput("busyB", int'(busyB), int'(mInFrame));
    checkOutput("ferrCntB", int'(ferrCntB), mFerr2);
    checkOutput("ovfCntB", int'(ovfCntB), mOvf2);
    if (ferrA) ferrSeen++;
  endtask

  function automatic logic pickRdy();
    if (rdyMode == 0) return 1'b0;
    if (rdyMode == 1) return 1'b1;
    return ($urandom_range(0, 2) != 0);
  endfunction

  task automatic applyStimulus(input logic ce, input logic d);
    dce_n = ce;
    din   = d;
    rdy   = pickRdy();
    @(posedge dclk);
    if (!rst_n) modelReset();
    else modelEdge();
    #1;
    checkAll();
  endtask

  task automatic sendFrame(input logic [DW-1:0] value);
    applyStimulus(1'b0, logic'($urandom_range(0, 1)));
    for (int k = 0; k < DW; k++) applyStimulus(1'b1, value[k]);
  endtask

  task automatic sendShort(input int nBits);
    applyStimulus(1'b0, logic'($urandom_range(0, 1)));
    for (int k = 0; k < nBits; k++) applyStimulus(1'b1, logic'($urandom_range(0, 1)));
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, logic'($urandom_range(0, 1)));
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    dce_n = 1'b1;
    #1;
    modelReset();
    checkAll();
    for (int k = 0; k < 2; k++) applyStimulus(1'b1, logic'($urandom_range(0, 1)));
    rst_n = 1'b1;
  endtask

  initial begin
    modelReset();
    #2;
    doReset();

    $display("[TB] single frame 0xA5");
    rdyMode = 1;
    sendFrame(8'hA5);
    checkOutput("t1_word", int'(ifA.word_o), 'hA5);
    checkOutput("t1_vld", int'(ifA.vld_o), 1);
    idleCycles(2);

    $display("[TB] back-to-back frames");
    sendFrame(8'h01);
    checkOutput("t2_w0", int'(ifA.word_o), 'h01);
    sendFrame(8'h80);
    checkOutput("t2_w1", int'(ifA.word_o), 'h80);
    sendFrame(8'hFF);
    checkOutput("t2_w2", int'(ifA.word_o), 'hFF);
    checkOutput("t2_ferrCnt", int'(ferrCntA), 0);
    idleCycles(2);

    $display("[TB] short frame then 0x3C");
    sendShort(5);
    sendFrame(8'h3C);
    checkOutput("t3_word", int'(ifA.word_o), 'h3C);
    checkOutput("t3_ferrCnt", int'(ferrCntA), 1);
    idleCycles(2);

    $display("[TB] overrun with ready low");
    doReset();
    rdyMode = 0;
    sendFrame(8'h11);
    sendFrame(8'h22);
    checkOutput("t4_ovf", int'(ovfA), 1);
    idleCycles(1);
    checkOutput("t4_word", int'(ifA.word_o), 'h11);
    checkOutput("t4_ovfCnt", int'(ovfCntA), 1);
    rdyMode = 1;
    idleCycles(1);
    checkOutput("t4_vldDrop", int'(ifA.vld_o), 0);
    idleCycles(2);
    checkOutput("t4_wordHeld", int'(ifA.word_o), 'h11);

    $display("[TB] reset mid-frame");
    sendShort(4);
    doReset();
    sendFrame(8'h0F);
    checkOutput("t5_word", int'(ifA.word_o), 'h0F);
    checkOutput("t5_ferrCnt", int'(ferrCntA), 0);
    checkOutput("t5_ovfCnt", int'(ovfCntA), 0);
    idleCycles(2);

    $display("[TB] counter saturation");
    doReset();
    ferrSeen = 0;
    for (int n = 0; n < 5; n++) sendShort(3);
    sendFrame(8'h99);
    checkOutput("t6_pulses", ferrSeen, 5);
    checkOutput("t6_cntB", int'(ferrCntB), 3);
    checkOutput("t6_cntA", int'(ferrCntA), 5);
    idleCycles(2);

    $display("[TB] randomised traffic");
    for (int it = 0; it < 400; it++) begin
      int choice;
      choice  = $urandom_range(0, 19);
      rdyMode = ($urandom_range(0, 3) == 0) ? 0 : 2;
      if (choice < 12) sendFrame(DW'($urandom));
      else if (choice < 16) sendShort($urandom_range(0, DW - 1));
      else if (choice < 19) idleCycles($urandom_range(1, 3));
      else doReset();
    end
    rdyMode = 1;
    idleCycles(DW + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
